mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
Shares one multi-cycle 8x8 unsigned multiplier (`mul`: start/busy handshake, 16-bit result) among N_REQ requesters. Arbitration is round-robin. The block latches the granted operands, sequences the multiplier's start/busy protocol, and returns the product to the granted requester. A watchdog bounds the wait on the multiplier. The block sits between client datapaths and a single `mul` instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
OP_W, 8, operand width per requester
RES_W, 16, result width (2*OP_W)
TIMEOUT, 64, max cycles spent in WAIT_BUSY+WAIT_DONE before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  request pending, per requester
req_a  in  N_REQ*OP_W  operand a, requester i at bits [i*OP_W +: OP_W]
req_b  in  N_REQ*OP_W  operand b, same packing
req_ready  out  N_REQ  one-hot grant/accept pulse
rsp_valid  out  N_REQ  one-hot response pulse
rsp_result  out  RES_W  product, valid when any rsp_valid bit is set
rsp_err  out  1  timeout flag, qualified by rsp_valid
arb_busy  out  1  state != IDLE
mul_start  out  1  to mul start
mul_a  out  OP_W  to mul a_i
mul_b  out  OP_W  to mul b_i
mul_busy  in  1  from mul busy
mul_result  in  RES_W  from mul result

Behaviour:
- Single clock `clk`. Reset is synchronous, active-high, on `rst`.
- Reset values:
  - state=IDLE
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0
  - mul_start=0, mul_a=0, mul_b=0
  - grant pointer last=N_REQ-1, so requester 0 has top priority first
  - watchdog=0
- Request handshake:
  - Requester holds req_valid and operands stable until it sees req_ready[i]=1.
  - Dropping req_valid before the grant is legal; no grant is issued for it.
- States:
  - IDLE:
    - If any req_valid and mul_busy==0: pick g = first set bit scanning from last+1 with wrap.
    - req_ready[g]=1 combinationally this cycle; latch req_a/req_b[g] into op regs; last<=g; go ISSUE.
    - If mul_busy==1: no grant.
  - ISSUE:
    - mul_start=1, mul_a/mul_b=op regs; watchdog<=0; go WAIT_BUSY.
    - mul_start is high only in ISSUE (exactly one cycle).
  - WAIT_BUSY:
    - mul_a/mul_b held. If mul_busy==1, go WAIT_DONE.
    - Otherwise increment watchdog.
  - WAIT_DONE:
    - If mul_busy==0: rsp_result<=mul_result, rsp_err<=0, go RESP.
    - Otherwise increment watchdog.
  - Timeout:
    - In WAIT_BUSY or WAIT_DONE, when watchdog reaches TIMEOUT-1: rsp_result<=0, rsp_err<=1, go RESP.
    - Timeout takes priority over a same-cycle busy transition.
  - RESP:
    - rsp_valid[g]=1 for exactly one cycle; no backpressure; go IDLE.
- rsp_result and rsp_err hold their values until the next RESP.
- Latency with a multiplier whose busy is high for K cycles: req_ready to rsp_valid = K+3 cycles.
  - Issue-to-issue spacing is K+4 cycles (IDLE, ISSUE, WAIT_BUSY, K busy cycles, RESP).
- Arithmetic: unsigned. Products are passed through unmodified; no truncation (RES_W = 2*OP_W).
- Reset mid-operation: return to IDLE from any state on the next edge. Any in-flight response is discarded (no rsp_valid).
- Simultaneous requests: the pointer guarantees each continuously requesting client is served within N_REQ grants.

Decomposition:
- Package mul_arbiter_pkg holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, RESP=4 (3 bits)
  - default N_REQ, OP_W, RES_W, TIMEOUT constants
- Sub-module rr_picker (parameter N):
  - inputs: req vector, last pointer
  - outputs: one-hot grant, grant index, any
  - purely combinational, rotate-and-priority-encode
- The FSM, op regs, watchdog and response regs stay in mul_arbiter. The top-level wrapper instantiates mul_arbiter plus one mul.

Test Plan:
- Bench multiplier model: busy high 15 cycles after start, result=a*b.
- Single request: req0 a=3, b=5 -> req_ready[0] in cycle 0; mul_start 1 cycle later; rsp_valid[0] with rsp_result=15 and rsp_err=0 at cycle 18.
- Simultaneous: req0 (7*9) and req2 (255*255) raised together -> req0 served first (63); req2 granted in the IDLE cycle right after RESP, returns 65025.
- Fairness: all 4 requesters held continuously with distinct operands -> grant order 0,1,2,3,0,1; every rsp_result correct.
- Timeout: model keeps mul_busy stuck 0 after start, req1 4*4 -> rsp_valid[1] with rsp_err=1 and rsp_result=0 exactly TIMEOUT cycles after leaving ISSUE. Repeat with busy stuck 1 -> same; no further grants while mul_busy stays 1.
- Reset mid-op: assert rst in WAIT_DONE for req3 -> next cycle all outputs 0 and state IDLE. No rsp_valid for req3. The next request (req0 2*8) returns 16 with requester 0 at top priority.
- Withdrawn request: req1 valid for 1 cycle while the block is busy, then dropped -> req1 never granted; no rsp_valid[1].

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and the
// default parameter values used by mul_arbiter.
package mul_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_OP_W    = 8;
    localparam int DEF_RES_W   = 16;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker (purely combinational).
//   req   : request vector
//   last  : index of the most recent grant
//   grant : one-hot winner, empty when nothing requests
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // Walk the requesters starting just after 'last' and wrapping; the first
    // one found wins, so the previous winner drops to lowest priority.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!any && req[cand[IW-1:0]]) begin
                any                = 1'b1;
                idx                = cand[IW-1:0];
                grant[cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle start/busy multiplier among N_REQ requesters.
// A round-robin grant latches the winner's operands, the FSM issues a one-cycle
// start, waits for busy to rise and fall, and returns the product to the
// granted requester as a one-cycle pulse. A watchdog bounds the total time
// spent waiting on the multiplier; on expiry the response carries err=1.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_a/req_b    : per-requester request and packed operands
//   req_ready                : one-hot accept pulse (combinational, IDLE only)
//   rsp_valid/result/err     : one-hot response pulse, held product and error
//   arb_busy                 : block is not idle
//   mul_start/mul_a/mul_b    : to multiplier
//   mul_busy/mul_result      : from multiplier
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int OP_W    = DEF_OP_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*OP_W-1:0]   req_a,
    input  logic [N_REQ*OP_W-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    rsp_err,
    output logic                    arb_busy,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic                    mul_busy,
    input  logic [RES_W-1:0]        mul_result
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_t            state, state_nxt;
    logic [IW-1:0]     last;
    logic [OP_W-1:0]   op_a, op_b;
    logic [OP_W-1:0]   sel_a, sel_b;
    logic [WD_W-1:0]   watchdog;
    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              grant_en;
    logic              waiting;
    logic              wd_expired;

    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A new grant is only made while the multiplier is idle.
    assign grant_en   = (state == IDLE) && pick_any && !mul_busy;
    assign waiting    = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_en) begin
                    req_ready = pick_grant;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            // Timeout wins over a same-cycle busy edge.
            WAIT_BUSY: begin
                if (wd_expired)    state_nxt = RESP;
                else if (mul_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wd_expired || !mul_busy) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[last] = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= IW'(N_REQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            watchdog   <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                last <= pick_idx;
                op_a <= sel_a;
                op_b <= sel_b;
            end
            // Counts every cycle in either wait state, so the bound covers the
            // whole wait regardless of where the multiplier stalls.
            if (state == ISSUE)
                watchdog <= '0;
            else if (waiting)
                watchdog <= watchdog + WD_W'(1);
            if (waiting && wd_expired) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
            end else if (state == WAIT_DONE && !mul_busy) begin
                rsp_result <= mul_result;
                rsp_err    <= 1'b0;
            end
        end
    end

    assign mul_a    = op_a;
    assign mul_b    = op_b;
    assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter: a multiplier stand-in (busy K cycles, or stuck
// low / stuck high), a transaction-level reference that predicts every output
// each cycle from grant time, and directed plus randomized stimulus.
module tb_mul_arbiter;

    localparam int N  = 4;
    localparam int OW = 8;
    localparam int RW = 16;
    localparam int TO = 64;
    localparam int K  = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [OW-1:0]   op_a [N];
    logic [OW-1:0]   op_b [N];
    logic [N*OW-1:0] req_a, req_b;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [RW-1:0]   rsp_result;
    logic            rsp_err, arb_busy, mul_start;
    logic [OW-1:0]   mul_a, mul_b;
    logic            mul_busy;
    logic [RW-1:0]   mul_result;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*OW +: OW] = op_a[i];
            req_b[i*OW +: OW] = op_b[i];
        end
    end

    mul_arbiter #(.N_REQ(N), .OP_W(OW), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .arb_busy(arb_busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_result(mul_result)
    );

    // Multiplier stand-in. mode 0: busy K cycles; 1: busy never rises;
    // 2: busy rises on start and sticks until clr.
    int   mode = 0;
    logic clr  = 1'b0;
    int   bcnt = 0;
    always @(posedge clk) begin
        if (rst || clr) bcnt <= 0;
        else if (mul_start && mode != 1) begin
            bcnt       <= (mode == 2) ? 32'h7fff_ffff : K;
            mul_result <= mul_a * mul_b;
        end else if (bcnt > 0 && mode == 0) bcnt <= bcnt - 1;
    end
    assign mul_busy = (bcnt != 0);

    int checks = 0, fails = 0, cyc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int oh2i(logic [N-1:0] v);
        for (int j = 0; j < N; j++) if (v[j]) return j;
        return -1;
    endfunction

    // Reference: one transaction in flight, its response time fixed at grant.
    bit            m_act  = 1'b0;
    int            m_gcyc = 0, m_rcyc = 0;
    logic [1:0]    m_idx  = '0, m_last = 2'(N - 1);
    logic [OW-1:0] m_a = '0, m_b = '0;
    logic [RW-1:0] m_res = '0, m_rres = '0;
    logic          m_err = 1'b0, m_rerr = 1'b0;
    logic [N-1:0]  gflag = '0;

    int g_cyc[$], g_idx[$], s_cyc[$], r_cyc[$], r_idx[$], r_res[$], r_err[$];

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_rv;
        logic [1:0]   c, t;
        bit           found;
        e_ready = '0; e_rv = '0; found = 1'b0; c = '0; t = '0;
        if (!m_act && !mul_busy) begin
            for (int k = 1; k <= N; k++) begin
                t = 2'(int'(m_last) + k);
                if (!found && req_valid[t]) begin found = 1'b1; c = t; end
            end
            if (found) e_ready[c] = 1'b1;
        end
        if (m_act && cyc == m_rcyc) begin
            e_rv[m_idx] = 1'b1;
            m_rres = m_res;
            m_rerr = m_err;
        end
        chk("req_ready",  req_ready,  e_ready);
        chk("rsp_valid",  rsp_valid,  e_rv);
        chk("rsp_result", rsp_result, m_rres);
        chk("rsp_err",    rsp_err,    m_rerr);
        chk("arb_busy",   arb_busy,   m_act);
        chk("mul_start",  mul_start,  m_act && cyc == m_gcyc + 1);
        chk("mul_a",      mul_a,      m_a);
        chk("mul_b",      mul_b,      m_b);

        if (req_ready != 0) begin g_cyc.push_back(cyc); g_idx.push_back(oh2i(req_ready)); end
        if (mul_start) s_cyc.push_back(cyc);
        if (rsp_valid != 0) begin
            r_cyc.push_back(cyc); r_idx.push_back(oh2i(rsp_valid));
            r_res.push_back(int'(rsp_result)); r_err.push_back(int'(rsp_err));
        end
        gflag = req_ready & req_valid;

        if (found) begin
            m_act = 1'b1; m_gcyc = cyc; m_idx = c; m_last = c;
            m_a = op_a[c]; m_b = op_b[c];
            if (mode == 0) begin
                m_rcyc = cyc + K + 3; m_res = m_a * m_b; m_err = 1'b0;
            end else begin
                m_rcyc = cyc + TO + 2; m_res = '0; m_err = 1'b1;
            end
        end else if (m_act && cyc == m_rcyc) m_act = 1'b0;
        if (rst) begin
            m_act = 1'b0; m_last = 2'(N - 1); m_a = '0; m_b = '0;
            m_rres = '0; m_rerr = 1'b0;
        end
        cyc++;
    end

    bit refill = 1'b0;

    function automatic logic [OW-1:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return OW'($urandom);
        endcase
    endfunction

    // Advance one cycle; granted requesters drop (or reload when refilling).
    task automatic step();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            if (gflag[i]) begin
                if (refill) begin op_a[i] = pick_op(); op_b[i] = pick_op(); end
                else req_valid[i] = 1'b0;
            end
    endtask

    task automatic do_reset();
        req_valid = '0; rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        int b = 0;
        while (r_cyc.size() < n && b < 400) begin step(); b++; end
        chk({name, "_wait"}, r_cyc.size() >= n, 1);
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b);
        op_a[i] = a; op_b[i] = b; req_valid[i] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int g0, r0, s0, t0, cnt;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        step(); step(); rst = 1'b0;
        // Reset state
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_mul_a", mul_a, 0);

        // Single request 3*5
        g0 = g_cyc.size(); r0 = r_cyc.size(); s0 = s_cyc.size(); t0 = cyc;
        set_req(0, 8'd3, 8'd5);
        wait_rsp(r0 + 1, "single");
        if (r_cyc.size() > r0 && g_cyc.size() > g0 && s_cyc.size() > s0) begin
            chk("single_grant_cycle", g_cyc[g0], t0);
            chk("single_grant_idx", g_idx[g0], 0);
            chk("single_start_lat", s_cyc[s0] - g_cyc[g0], 1);
            chk("single_rsp_lat", r_cyc[r0] - g_cyc[g0], 18);
            chk("single_rsp_idx", r_idx[r0], 0);
            chk("single_result", r_res[r0], 15);
            chk("single_err", r_err[r0], 0);
        end

        // Simultaneous req0 7*9, req2 255*255
        do_reset();
        g0 = g_cyc.size(); r0 = r_cyc.size();
        set_req(0, 8'd7, 8'd9); set_req(2, 8'd255, 8'd255);
        wait_rsp(r0 + 2, "simul");
        if (r_cyc.size() > r0 + 1 && g_cyc.size() > g0 + 1) begin
            chk("simul_first_idx", g_idx[g0], 0);
            chk("simul_second_idx", g_idx[g0 + 1], 2);
            chk("simul_res0", r_res[r0], 63);
            chk("simul_res2", r_res[r0 + 1], 65025);
            chk("simul_back_to_back", g_cyc[g0 + 1] - r_cyc[r0], 1);
        end

        // Fairness: everyone requesting continuously
        do_reset();
        g0 = g_cyc.size(); r0 = r_cyc.size(); refill = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'(10 + i), 8'(20 + 3 * i));
        cnt = 0;
        while (g_cyc.size() < g0 + 6 && cnt < 400) begin step(); cnt++; end
        req_valid = '0; refill = 1'b0;
        chk("fair_grants", g_cyc.size() >= g0 + 6, 1);
        if (g_cyc.size() >= g0 + 6)
            for (int k = 0; k < 6; k++) chk("fair_order", g_idx[g0 + k], k % N);
        wait_rsp(r0 + (g_cyc.size() - g0), "fair");

        // Timeout with busy stuck low, then stuck high
        for (int m = 1; m <= 2; m++) begin
            mode = m;
            g0 = g_cyc.size(); r0 = r_cyc.size();
            set_req(1, 8'd4, 8'd4);
            wait_rsp(r0 + 1, "tmo");
            if (r_cyc.size() > r0 && g_cyc.size() > g0) begin
                chk("tmo_after_issue", r_cyc[r0] - (g_cyc[g0] + 2), TO);
                chk("tmo_idx", r_idx[r0], 1);
                chk("tmo_err", r_err[r0], 1);
                chk("tmo_result", r_res[r0], 0);
            end
        end
        g0 = g_cyc.size(); r0 = r_cyc.size();
        set_req(0, 8'd3, 8'd3);
        repeat (10) step();
        chk("stuck_no_grant", g_cyc.size(), g0);
        clr = 1'b1; step(); clr = 1'b0; mode = 0;
        wait_rsp(r0 + 1, "unstuck");
        if (r_cyc.size() > r0) chk("unstuck_result", r_res[r0], 9);

        // Reset in WAIT_DONE for req3
        do_reset();
        g0 = g_cyc.size();
        set_req(3, 8'd10, 8'd11);
        cnt = 0;
        while (g_cyc.size() == g0 && cnt < 50) begin step(); cnt++; end
        repeat (5) step();
        rst = 1'b1; step();
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_arb_busy", arb_busy, 0);
        chk("midrst_mul_start", mul_start, 0);
        chk("midrst_mul_a", mul_a, 0);
        chk("midrst_mul_b", mul_b, 0);
        chk("midrst_rsp_result", rsp_result, 0);
        rst = 1'b0;
        r0 = r_cyc.size();
        repeat (25) step();
        chk("midrst_no_rsp", r_cyc.size(), r0);
        g0 = g_cyc.size();
        set_req(0, 8'd2, 8'd8); set_req(2, 8'd1, 8'd1);
        wait_rsp(r0 + 2, "postrst");
        if (r_cyc.size() > r0 && g_cyc.size() > g0) begin
            chk("postrst_first_idx", g_idx[g0], 0);
            chk("postrst_result", r_res[r0], 16);
        end

        // Withdrawn request
        do_reset();
        g0 = g_cyc.size(); r0 = r_cyc.size();
        set_req(0, 8'd1, 8'd2);
        step(); step();
        set_req(1, 8'd5, 8'd5);
        step();
        req_valid[1] = 1'b0;
        wait_rsp(r0 + 1, "withdraw");
        repeat (5) step();
        cnt = 0;
        for (int k = g0; k < g_cyc.size(); k++) if (g_idx[k] == 1) cnt++;
        for (int k = r0; k < r_cyc.size(); k++) if (r_idx[k] == 1) cnt++;
        chk("withdraw_never_served", cnt, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, pick_op(), pick_op());
                else if (req_valid[i] && !gflag[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
        end
        rst = 1'b0; req_valid = '0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
